decoder_stream: RTL and testbench
=================================

// Module: decoder_stream
// PURPOSE
// - Parametrised, registered N-to-M decoder with valid/ready streaming handshake.
// - Replaces the fixed 3-to-8 registered decoder for select, chip-enable and lane-enable generation.
// - Adds runtime output modes, out-of-range detection, backpressure with full throughput, and an error counter.
// PARAMETERS
// - SEL_W      3  width of select input
// - NUM_OUT    8  number of decoded outputs; 2 <= NUM_OUT <= 2**SEL_W
// - ERR_CNT_W  8  width of saturating error counter
// PORTS
// - clk        in   1          single clock, rising edge
// - rst_n      in   1          asynchronous reset, active-low; deassertion synchronised externally
// - in_valid   in   1          input beat valid
// - in_ready   out  1          block can accept a beat
// - in_sel     in   SEL_W      select value
// - in_mode    in   2          0 one-hot, 1 one-cold, 2 thermometer, 3 reserved
// - out_valid  out  1          decoded beat valid
// - out_ready  in   1          downstream accepts beat
// - out_y      out  NUM_OUT    decoded word
// - out_err    out  1          beat was out-of-range or reserved mode; travels with out_y
// - err_cnt    out  ERR_CNT_W  count of accepted error beats, saturating
// - err_clr    in   1          synchronous clear of err_cnt
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0, out_y=0, out_err=0, err_cnt=0, skid empty. in_ready=1 while in reset.
// - Handshake: a beat transfers when valid&&ready on the same edge. out_valid/out_y/out_err hold stable while out_valid&&!out_ready.
// - Decode for sel < NUM_OUT:
//   - one-hot: y[sel]=1, all other bits 0.
//   - one-cold: ~one-hot.
//   - thermometer: y[i]=1 for i<=sel.
// - Error beats: sel >= NUM_OUT, or mode=3 -> y=0, err=1 (all modes). Error beats still complete the handshake.
// - Latency: 1 cycle; an accepted beat appears on out_* after the next edge.
// - Pipeline: one output register plus one skid entry.
//   - in_ready = !skid_valid (registered, no comb path from out_ready).
//   - Capture into output reg: output empty, or out_ready=1. Source is the skid if it is full, otherwise the input.
//   - Capture into skid: in accept while output is full and out_ready=0.
//   - Sustains 1 beat/cycle with out_ready=1; absorbs one beat when out_ready drops.
// - Ordering is strictly preserved; no beat is dropped or duplicated.
// - Decode happens at input capture. Skid stores the decoded y/err, not the raw sel.
// - err_cnt increments on each accepted input error beat and saturates at all-ones.
//   - err_clr=1 forces 0 next edge; clr wins over a simultaneous increment.
// - in_* is don't-care when in_valid=0; X on in_sel must not propagate while in_valid=0.
// - Reset mid-transfer discards the output and skid contents; no beat survives reset.
// STRUCTURE
// - Package decoder_pkg:
//   - dec_mode_e enum (MODE_ONEHOT=0, MODE_ONECOLD=1, MODE_THERM=2, MODE_RSVD=3).
//   - function dec_word(sel, mode) returning {err, y}; this function is the single source of truth for decode.
// - Sub-module dec_skid_buf (parametrised width): output register and skid entry holding {err, y}.
// - Top level: decode function, input-side handshake, err_cnt.
// TESTING (SEL_W=3, NUM_OUT=8 unless stated)
// - Reset: hold rst_n=0 mid-stream with beats in output and skid.
//   -> out_valid=0, out_y=0, err_cnt=0, in_ready=1 immediately; after release, nothing stale appears.
// - Streaming one-hot: out_ready=1, sel=0..7 back to back.
//   -> y=01,02,04,...,80 on consecutive cycles, 1-cycle latency, in_ready stays 1.
// - Modes: sel=3 with mode 1 -> y=F7; mode 2 -> y=0F. sel=7 with mode 2 -> y=FF.
//   mode 3 with any sel -> y=00, err=1, err_cnt+1.
// - Out-of-range: NUM_OUT=6, sel=6 and sel=7 -> y=00 (6 bits), err=1, err_cnt=2; sel=5 -> y=20, err=0.
// - Backpressure: stream sel=1,2,3 and drop out_ready for 3 cycles after the first beat.
//   -> out_y holds 02, skid takes 04, in_ready=0, sel=3 held upstream.
//   -> on release: 04, 08 in order, no loss or duplication.
// - Counter: 260 error beats (ERR_CNT_W=8) -> err_cnt saturates at FF.
//   err_clr together with an error beat -> err_cnt=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared decode types and the one decode function used by the streaming decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'd0,
        MODE_ONECOLD = 2'd1,
        MODE_THERM   = 2'd2,
        MODE_RSVD    = 2'd3
    } dec_mode_e;

    // Widest select the decode function supports; instances slice what they need.
    localparam int unsigned DEC_MAX_SEL_W = 8;
    localparam int unsigned DEC_MAX_OUT   = 1 << DEC_MAX_SEL_W;

    // One bit wider than a select so that NUM_OUT itself is representable.
    typedef logic [DEC_MAX_SEL_W:0]  dec_idx_t;
    // Bit DEC_MAX_OUT carries the error flag, bits below it the decoded word.
    typedef logic [DEC_MAX_OUT:0]    dec_word_t;

    // Returns {err, y}. Out-of-range selects and the reserved mode give y=0, err=1.
    function automatic dec_word_t dec_word(input logic [DEC_MAX_SEL_W-1:0] sel,
                                           input dec_mode_e                 mode,
                                           input dec_idx_t                  num_out);
        dec_word_t w;
        dec_idx_t  sel_x;
        dec_idx_t  idx;
        w     = '0;
        sel_x = {1'b0, sel};
        if (mode == MODE_RSVD || sel_x >= num_out) begin
            w[DEC_MAX_OUT] = 1'b1;
        end else begin
            for (int i = 0; i < int'(DEC_MAX_OUT); i++) begin
                idx = dec_idx_t'(i);
                if (idx < num_out) begin
                    case (mode)
                        MODE_ONEHOT:  w[idx] = (idx == sel_x);
                        MODE_ONECOLD: w[idx] = (idx != sel_x);
                        MODE_THERM:   w[idx] = (idx <= sel_x);
                        default:      w[idx] = 1'b0;
                    endcase
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Output register plus one skid entry; in_ready is purely registered.
module dec_skid_buf
    import decoder_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         in_accept;
    logic         out_load;

    // Next state: refill the output from skid first, park a beat in skid when stalled.
    always_comb begin
        in_accept    = in_valid && !skid_valid_q;
        out_load     = !out_valid_q || out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_load) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_accept;
                if (in_accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers; reset empties both stages so no beat survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/decoder_stream.sv
// Registered N-to-M decoder with valid/ready streaming and a saturating error counter.
module decoder_stream
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned NUM_OUT   = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OUT-1:0]   out_y,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic [SEL_W-1:0]     sel_gated;
    logic [1:0]           mode_gated;
    dec_word_t            dec_full;
    logic                 dec_err;
    logic [NUM_OUT-1:0]   dec_y;
    logic                 unused_dec;
    logic                 in_accept;
    logic [NUM_OUT:0]     out_word;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Decode at input capture; inputs are masked when idle so X on in_sel stays contained.
    always_comb begin
        sel_gated  = in_valid ? in_sel  : '0;
        mode_gated = in_valid ? in_mode : 2'd0;
        dec_full   = dec_word(DEC_MAX_SEL_W'(sel_gated), dec_mode_e'(mode_gated),
                              dec_idx_t'(NUM_OUT));
        dec_y      = dec_full[NUM_OUT-1:0];
        dec_err    = dec_full[DEC_MAX_OUT];
        unused_dec = ^dec_full;
    end

    assign in_accept = in_valid && in_ready;

    dec_skid_buf #(
        .W (NUM_OUT + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_err, dec_y}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_word)
    );

    assign out_err = out_word[NUM_OUT];
    assign out_y   = out_word[NUM_OUT-1:0];

    // Error counter: clear wins, otherwise count accepted error beats up to all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (in_accept && dec_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_decoder_stream.sv
// Randomised and directed bench for decoder_stream against a queue-based reference model.
module tb_decoder_stream;

    localparam int SEL_W     = 3;
    localparam int NUM_OUT   = 8;
    localparam int ERR_CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_sel = '0;
    logic [1:0] in_mode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic       out_err;
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;

    logic       in_valid6 = 1'b0;
    logic       in_ready6;
    logic [2:0] in_sel6 = '0;
    logic [1:0] in_mode6 = '0;
    logic       out_valid6;
    logic       out_ready6 = 1'b0;
    logic [5:0] out_y6;
    logic       out_err6;
    logic [7:0] err_cnt6;
    logic       err_clr6 = 1'b0;

    int         errorCount = 0;
    int         checkCount = 0;
    logic [8:0] expQ[$];
    int         modelErrCnt = 0;

    always #5 clk = ~clk;

    decoder_stream #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    decoder_stream #(.SEL_W(SEL_W), .NUM_OUT(6), .ERR_CNT_W(ERR_CNT_W)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_sel(in_sel6), .in_mode(in_mode6), .out_valid(out_valid6), .out_ready(out_ready6),
        .out_y(out_y6), .out_err(out_err6), .err_cnt(err_cnt6), .err_clr(err_clr6)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference decode written from the arithmetic meaning of each mode; returns {err, y}.
    function automatic logic [8:0] modelWord(input int sel, input int mode, input int n);
        int y;
        if (mode == 3 || sel >= n) return {1'b1, 8'h00};
        case (mode)
            0:       y = 1 << sel;
            1:       y = ((1 << n) - 1) ^ (1 << sel);
            default: y = (2 << sel) - 1;
        endcase
        return {1'b0, y[7:0]};
    endfunction

    // One clock of stimulus; the model predicts handshake and data from queue occupancy.
    task automatic applyStimulus(input bit v, input int sel, input int mode,
                                 input bit ordy, input bit clr, output bit accepted);
        logic [8:0] head;
        logic [8:0] w;
        bit         expReady;
        bit         expValid;
        in_valid  = v;
        in_sel    = 3'(sel);
        in_mode   = 2'(mode);
        out_ready = ordy;
        err_clr   = clr;
        #1;
        expReady = expQ.size() < 2;
        expValid = expQ.size() > 0;
        checkOutput("in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        if (expValid) begin
            head = expQ[0];
            checkOutput("out_y", 32'(out_y), 32'(head[7:0]));
            checkOutput("out_err", 32'(out_err), 32'(head[8]));
            if (ordy) void'(expQ.pop_front());
        end
        accepted = v && expReady;
        w = modelWord(sel, mode, NUM_OUT);
        if (accepted) expQ.push_back(w);
        if (clr) modelErrCnt = 0;
        else if (accepted && w[8] && modelErrCnt < 255) modelErrCnt++;
        @(posedge clk);
        #1;
        checkOutput("err_cnt", 32'(err_cnt), 32'(modelErrCnt));
    endtask

    initial begin
        bit acc;
        int beats[$];
        int curSel;
        int curMode;
        bit pending;
        bit readyPat[8];
        int sels6[3];

        // Reset values while reset is held.
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_y", 32'(out_y), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back one-hot stream with no backpressure.
        for (int s = 0; s < 8; s++) applyStimulus(1'b1, s, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Mode coverage including the reserved mode.
        applyStimulus(1'b1, 3, 1, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 3, 2, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 7, 2, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 5, 3, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 0, 3, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Backpressure: sel 1,2,3 with out_ready low for three cycles after the first beat.
        readyPat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        beats = '{1, 2, 3};
        for (int c = 0; c < 8; c++) begin
            if (beats.size() > 0) begin
                applyStimulus(1'b1, beats[0], 0, readyPat[c], 1'b0, acc);
                if (acc) void'(beats.pop_front());
            end else begin
                applyStimulus(1'b0, 0, 0, readyPat[c], 1'b0, acc);
            end
        end

        // Saturation of the error counter, then clear racing an error beat.
        for (int k = 0; k < 260; k++) applyStimulus(1'b1, k % 8, 3, 1'b1, 1'b0, acc);
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'hFF);
        applyStimulus(1'b1, 2, 3, 1'b1, 1'b1, acc);
        checkOutput("err_cnt_clr", 32'(err_cnt), 32'h00);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Randomised traffic; upstream holds a refused beat until it is taken.
        pending = 1'b0;
        curSel  = 0;
        curMode = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!pending && ($urandom_range(99) < 75)) begin
                pending = 1'b1;
                curSel  = int'($urandom_range(7));
                curMode = ($urandom_range(99) < 15) ? 3 : int'($urandom_range(2));
            end
            applyStimulus(pending, pending ? curSel : int'($urandom_range(7)), curMode,
                          $urandom_range(99) < 70, $urandom_range(99) < 2, acc);
            if (acc) pending = 1'b0;
        end
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Fill output and skid with error beats, then reset mid-stream.
        applyStimulus(1'b1, 1, 3, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 2, 3, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 4, 0, 1'b0, 1'b0, acc);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_y", 32'(out_y), 32'd0);
        checkOutput("midrst_out_err", 32'(out_err), 32'd0);
        checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        expQ.delete();
        modelErrCnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 6, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Six-output instance: out-of-range selects and the top valid select.
        sels6      = '{6, 7, 5};
        out_ready6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [8:0] w6;
            in_valid6 = 1'b1;
            in_sel6   = 3'(sels6[k]);
            in_mode6  = 2'd0;
            #1;
            checkOutput("n6_in_ready", 32'(in_ready6), 32'd1);
            @(posedge clk);
            #1;
            w6 = modelWord(sels6[k], 0, 6);
            checkOutput("n6_out_valid", 32'(out_valid6), 32'd1);
            checkOutput("n6_out_y", 32'(out_y6), 32'(w6[5:0]));
            checkOutput("n6_out_err", 32'(out_err6), 32'(w6[8]));
        end
        in_valid6 = 1'b0;
        checkOutput("n6_err_cnt", 32'(err_cnt6), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("n6_drained", 32'(out_valid6), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
